// File: rtl/line_word_buffer.sv
// Single-line holding buffer: registered word read, byte-masked write merge,
// dirty tracking, and beat-wise serialise/deserialise over valid/ready.

module lwb_word_lane #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0]   word_q_i,
  input  logic                load_i,
  input  logic [WORD_W-1:0]   load_word_i,
  input  logic                des_hit_i,
  input  logic [WORD_W-1:0]   des_word_i,
  input  logic                wr_hit_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic [WORD_W/8-1:0] wr_be_i,
  output logic [WORD_W-1:0]   word_d_o
);
  always_comb begin
    word_d_o = word_q_i;
    if (load_i) begin
      word_d_o = load_word_i;
    end else if (des_hit_i) begin
      word_d_o = des_word_i;
    end else if (wr_hit_i) begin
      for (int b = 0; b < WORD_W/8; b++)
        if (wr_be_i[b]) word_d_o[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end
endmodule

module line_word_buffer #(
  parameter int WORD_W     = 16,
  parameter int WORDS      = 8,
  parameter int BEAT_WORDS = 1,
  localparam int LINE_W    = WORD_W*WORDS,
  localparam int BEAT_W    = WORD_W*BEAT_WORDS,
  localparam int BEATS     = WORDS/BEAT_WORDS,
  localparam int SEL_W     = $clog2(WORDS),
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                line_load_i,
  input  logic [LINE_W-1:0]   line_in_i,
  output logic [LINE_W-1:0]   line_out_o,
  input  logic [SEL_W-1:0]    word_sel_i,
  input  logic                rd_en_i,
  output logic [WORD_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  input  logic                wr_en_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic [WORD_W/8-1:0] wr_be_i,
  output logic                dirty_o,
  input  logic                ser_start_i,
  output logic [BEAT_W-1:0]   ser_data_o,
  output logic                ser_valid_o,
  input  logic                ser_ready_i,
  output logic                ser_last_o,
  input  logic                des_start_i,
  input  logic [BEAT_W-1:0]   des_data_i,
  input  logic                des_valid_i,
  output logic                des_ready_o,
  output logic                xfer_done_o,
  output logic                busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_SER, S_DES} state_e;

  state_e                         state_q;
  logic [WORDS-1:0][WORD_W-1:0]   line_q, line_d;
  logic [CNT_W-1:0]               cnt_q;
  logic [WORD_W-1:0]              rd_data_q;
  logic                           rd_valid_q, dirty_q, ser_valid_q, des_ready_q;
  logic                           xfer_done_q, busy_q;
  logic                           idle, load_go, wr_go, cnt_last;

  assign idle     = (state_q == S_IDLE);
  assign load_go  = idle && line_load_i;
  // Write loses to line_load and des_start issued in the same cycle.
  assign wr_go    = idle && !line_load_i && !des_start_i && wr_en_i;
  assign cnt_last = (cnt_q == CNT_W'(BEATS-1));

  for (genvar i = 0; i < WORDS; i++) begin : g_lane
    logic des_hit, wr_hit;
    assign des_hit = (state_q == S_DES) && des_valid_i && (cnt_q == CNT_W'(i/BEAT_WORDS));
    assign wr_hit  = wr_go && (word_sel_i == SEL_W'(i));
    lwb_word_lane #(.WORD_W(WORD_W)) u_lane (
      .word_q_i    (line_q[i]),
      .load_i      (load_go),
      .load_word_i (line_in_i[i*WORD_W +: WORD_W]),
      .des_hit_i   (des_hit),
      .des_word_i  (des_data_i[(i%BEAT_WORDS)*WORD_W +: WORD_W]),
      .wr_hit_i    (wr_hit),
      .wr_data_i   (wr_data_i),
      .wr_be_i     (wr_be_i),
      .word_d_o    (line_d[i])
    );
  end

  for (genvar j = 0; j < BEAT_WORDS; j++) begin : g_beat
    assign ser_data_o[j*WORD_W +: WORD_W] = line_q[SEL_W'(int'(cnt_q)*BEAT_WORDS + j)];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      dirty_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      des_ready_q <= 1'b0;
      xfer_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      line_q      <= line_d;
      rd_valid_q  <= rd_en_i;
      xfer_done_q <= 1'b0;
      if (rd_en_i) rd_data_q <= line_q[word_sel_i];
      case (state_q)
        S_IDLE: begin
          if (line_load_i) begin
            dirty_q <= 1'b0;
          end else if (des_start_i) begin
            state_q     <= S_DES;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            des_ready_q <= 1'b1;
          end else if (wr_en_i) begin
            if (|wr_be_i) dirty_q <= 1'b1;
          end else if (ser_start_i) begin
            state_q     <= S_SER;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            ser_valid_q <= 1'b1;
          end
        end
        S_SER: begin
          if (ser_ready_i) begin
            if (cnt_last) begin
              state_q     <= S_IDLE;
              cnt_q       <= '0;
              busy_q      <= 1'b0;
              ser_valid_q <= 1'b0;
              xfer_done_q <= 1'b1;
              dirty_q     <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DES: begin
          if (des_valid_i) begin
            if (cnt_last) begin
              state_q     <= S_IDLE;
              cnt_q       <= '0;
              busy_q      <= 1'b0;
              des_ready_q <= 1'b0;
              xfer_done_q <= 1'b1;
              dirty_q     <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign line_out_o  = line_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign dirty_o     = dirty_q;
  assign ser_valid_o = ser_valid_q;
  assign ser_last_o  = ser_valid_q && cnt_last;
  assign des_ready_o = des_ready_q;
  assign xfer_done_o = xfer_done_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_line_word_buffer.sv
// Directed bench for line_word_buffer: default 1-word beats plus a 2-word-beat instance.

module tb_line_word_buffer;
  logic         clk = 1'b0;
  logic         rst, line_load, rd_en, wr_en, ser_start, ser_ready, des_start, des_valid;
  logic [127:0] line_in;
  logic [2:0]   word_sel;
  logic [15:0]  wr_data, des_data;
  logic [1:0]   wr_be;
  logic [31:0]  des_data2;
  logic [127:0] line_out, line_out2;
  logic [15:0]  rd_data, rd_data2, ser_data;
  logic [31:0]  ser_data2;
  logic         rd_valid, dirty, ser_valid, ser_last, des_ready, xfer_done, busy;
  logic         rd_valid2, dirty2, ser_valid2, ser_last2, des_ready2, xfer_done2, busy2;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] LINE_A = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  always #5 clk = ~clk;

  line_word_buffer dut (
    .clk_i(clk), .rst_i(rst), .line_load_i(line_load), .line_in_i(line_in), .line_out_o(line_out),
    .word_sel_i(word_sel), .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_be_i(wr_be), .dirty_o(dirty),
    .ser_start_i(ser_start), .ser_data_o(ser_data), .ser_valid_o(ser_valid), .ser_ready_i(ser_ready),
    .ser_last_o(ser_last), .des_start_i(des_start), .des_data_i(des_data), .des_valid_i(des_valid),
    .des_ready_o(des_ready), .xfer_done_o(xfer_done), .busy_o(busy)
  );

  line_word_buffer #(.BEAT_WORDS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .line_load_i(line_load), .line_in_i(line_in), .line_out_o(line_out2),
    .word_sel_i(word_sel), .rd_en_i(rd_en), .rd_data_o(rd_data2), .rd_valid_o(rd_valid2),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_be_i(wr_be), .dirty_o(dirty2),
    .ser_start_i(ser_start), .ser_data_o(ser_data2), .ser_valid_o(ser_valid2), .ser_ready_i(ser_ready),
    .ser_last_o(ser_last2), .des_start_i(des_start), .des_data_i(des_data2), .des_valid_i(des_valid),
    .des_ready_o(des_ready2), .xfer_done_o(xfer_done2), .busy_o(busy2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int cyc;
    bit part_done;
    {rst, line_load, rd_en, wr_en, ser_start, ser_ready, des_start, des_valid} = '0;
    line_in = '0; word_sel = '0; wr_data = '0; des_data = '0; wr_be = '0; des_data2 = '0;

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_line", line_out, 128'h0);
    chk("rst_flags", {dirty, busy, rd_valid, ser_valid, des_ready, xfer_done}, 6'b0);

    rd_en = 1'b1; word_sel = 3'd5; tick(); rd_en = 1'b0;
    chk("rst_rd", {rd_valid, rd_data}, {1'b1, 16'h0000});
    tick();
    chk("rd_valid_1cyc", rd_valid, 1'b0);

    // line_load outranks ser_start in the same cycle
    line_load = 1'b1; line_in = LINE_A; ser_start = 1'b1; tick();
    line_load = 1'b0; ser_start = 1'b0;
    chk("load_prio_busy", busy, 1'b0);
    rd_en = 1'b1; word_sel = 3'd3; tick(); rd_en = 1'b0;
    chk("load_rd3", rd_data, 16'h3333);

    wr_en = 1'b1; wr_data = 16'hABCD; wr_be = 2'b00; tick(); wr_en = 1'b0;
    chk("be0_dirty", dirty, 1'b0);
    chk("be0_line", line_out, LINE_A);

    wr_en = 1'b1; wr_be = 2'b01; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_old", rd_data, 16'h3333);
    chk("merge_dirty", dirty, 1'b1);
    chk("merge_word3", line_out[3*16 +: 16], 16'h33CD);
    chk("merge_word2", line_out[2*16 +: 16], 16'h2222);

    // restore word 3 while leaving dirty set
    wr_en = 1'b1; wr_data = 16'h3333; wr_be = 2'b11; tick(); wr_en = 1'b0;
    chk("restore_dirty", dirty, 1'b1);

    ser_start = 1'b1; tick(); ser_start = 1'b0;
    chk("ser_busy", {busy, ser_valid}, 2'b11);
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      ser_ready = (cyc % 2 == 0);
      chk("ser_data", ser_data, 16'h1111 * k[15:0]);
      chk("ser_last", ser_last, k == 7);
      if (ser_ready) k++;
      cyc++;
      tick();
    end
    ser_ready = 1'b0;
    chk("ser_beats", k, 8);
    chk("ser_done", {xfer_done, busy, ser_valid, dirty}, 4'b1000);
    tick();
    chk("ser_done_pulse", xfer_done, 1'b0);

    des_start = 1'b1; tick(); des_start = 1'b0;
    chk("des_enter", {busy, des_ready}, 2'b11);
    k = 0; cyc = 0; part_done = 1'b0;
    wr_en = 1'b1; word_sel = 3'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
    while (k < 8 && cyc < 40) begin
      des_valid = (cyc % 3 != 2);
      des_data  = 16'hA000 + k[15:0];
      if (k == 4 && !part_done) begin
        part_done = 1'b1;
        chk("des_part_new", line_out[3*16 +: 16], 16'hA003);
        chk("des_part_old", line_out[4*16 +: 16], 16'h4444);
      end
      if (des_valid) k++;
      cyc++;
      tick();
    end
    des_valid = 1'b0; wr_en = 1'b0;
    chk("des_beats", k, 8);
    chk("des_done", {xfer_done, busy, des_ready, dirty}, 4'b1000);
    for (int i = 0; i < 8; i++) chk("des_word", line_out[i*16 +: 16], 16'hA000 + 16'(i));
    tick();
    chk("des_done_pulse", xfer_done, 1'b0);

    line_load = 1'b1; line_in = LINE_A; tick(); line_load = 1'b0;
    ser_start = 1'b1; tick(); ser_start = 1'b0;
    ser_ready = 1'b1; tick(); tick(); tick();
    chk("mid_ser_data", ser_data, 16'h3333);
    rst = 1'b1; ser_ready = 1'b0; tick(); rst = 1'b0;
    chk("midrst_flags", {ser_valid, busy, ser_last, xfer_done}, 4'b0);
    chk("midrst_line", line_out, 128'h0);

    // 2-word beats: both instances serialise together; only dut2 is checked here
    line_load = 1'b1; line_in = LINE_A; tick(); line_load = 1'b0;
    ser_start = 1'b1; tick(); ser_start = 1'b0; ser_ready = 1'b1;
    chk("b2_ser_data0", ser_data2, 32'h1111_0000);
    chk("b2_ser_last0", ser_last2, 1'b0);
    tick();
    chk("b2_ser_data1", ser_data2, 32'h3333_2222);
    tick();
    chk("b2_ser_data2", ser_data2, 32'h5555_4444);
    tick();
    chk("b2_ser_data3", ser_data2, 32'h7777_6666);
    chk("b2_ser_last3", ser_last2, 1'b1);
    tick();
    chk("b2_done", {xfer_done2, busy2, ser_valid2}, 3'b100);
    chk("b1_still_busy", busy, 1'b1);
    ser_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
